// File: rtl/digital_bridge_pkg.sv
// ---------------------------------------------------------------------------
// digital_bridge_pkg
//   Shared definitions for the digital I/O bridge: frame FSM state encoding
//   and the elaboration-time helpers that size beat counts and counters.
// ---------------------------------------------------------------------------
package digital_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TX     = 2'd1,
        ST_RX     = 2'd2,
        ST_COMMIT = 2'd3
    } bridge_state_e;

    // Number of LANE-sized beats needed to carry a vector of width a.
    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Counter width able to index 0..n-1; never narrower than one bit so a
    // single-beat vector still gets a legal counter.
    function automatic int clog2_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/digital_io_bridge_if.sv
// ---------------------------------------------------------------------------
// digital_io_bridge_if
//   Host link of the bridge: an outbound beat stream (tx_*) and an inbound
//   beat stream (rx_*), each a valid/ready handshake LANE_WIDTH bits wide.
//   master : bridge side (drives tx_data/tx_valid/rx_ready)
//   slave  : host side   (drives tx_ready/rx_data/rx_valid)
// ---------------------------------------------------------------------------
interface digital_io_bridge_if #(
    parameter int LANE_WIDTH = 8
);
    logic [LANE_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [LANE_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/bridge_lane_mux.sv
// ---------------------------------------------------------------------------
// bridge_lane_mux
//   Chunk select / insert between a VEC_W-bit vector and LANE_W-bit beats.
//   Chunk k covers vector bits [k*LANE_W +: LANE_W].
//   vec_i  : source vector
//   idx_i  : chunk index
//   lane_i : beat to insert at chunk idx_i
//   lane_o : chunk idx_i of vec_i, bits past VEC_W read as 0
//   vec_o  : vec_i with chunk idx_i replaced by lane_i, bits past VEC_W dropped
// ---------------------------------------------------------------------------
module bridge_lane_mux #(
    parameter int VEC_W  = 8,
    parameter int LANE_W = 8,
    parameter int IDX_W  = 1
) (
    input  logic [VEC_W-1:0]  vec_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [LANE_W-1:0] lane_i,
    output logic [LANE_W-1:0] lane_o,
    output logic [VEC_W-1:0]  vec_o
);
    // Walking the vector bit by bit (rather than slicing a padded copy)
    // handles the ragged last chunk and VEC_W < LANE_W with no special cases.
    always_comb begin
        lane_o = '0;
        vec_o  = vec_i;
        for (int i = 0; i < VEC_W; i++) begin
            if (idx_i == IDX_W'(i / LANE_W)) begin
                lane_o[i % LANE_W] = vec_i[i];
                vec_o[i]           = lane_i[i % LANE_W];
            end
        end
    end
endmodule

// File: rtl/digital_io_bridge.sv
// ---------------------------------------------------------------------------
// digital_io_bridge
//   Framed exchange between SoC pin vectors and a host link. A frame
//   snapshots out_vec, streams it out LSB chunk first, streams in a new input
//   vector and commits it to in_vec in a single cycle.
//   clk, rst     : clock, asynchronous active-low reset
//   out_vec      : live SoC outputs (snapshotted at frame start)
//   in_vec       : committed host inputs, updated only at COMMIT
//   frame_req    : start a frame (coalesced into one pending while busy)
//   auto_en      : chain a new frame after each completed one
//   busy         : frame in progress
//   frame_done   : one-cycle pulse during COMMIT
//   timeout_err  : sticky watchdog abort flag, cleared by frame_req
//   link         : tx/rx beat handshakes (master side)
// ---------------------------------------------------------------------------
module digital_io_bridge
    import digital_bridge_pkg::*;
#(
    parameter int                  OUT_WIDTH  = 147,
    parameter int                  IN_WIDTH   = 43,
    parameter int                  LANE_WIDTH = 8,
    parameter logic [IN_WIDTH-1:0] IN_RESET   = {IN_WIDTH{1'b0}},
    parameter int                  TIMEOUT    = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OUT_WIDTH-1:0] out_vec,
    output logic [IN_WIDTH-1:0]  in_vec,
    input  logic                 frame_req,
    input  logic                 auto_en,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 timeout_err,
    digital_io_bridge_if.master  link
);
    localparam int OUT_BEATS = ceil_div(OUT_WIDTH, LANE_WIDTH);
    localparam int IN_BEATS  = ceil_div(IN_WIDTH, LANE_WIDTH);
    localparam int TXC_W     = clog2_w(OUT_BEATS);
    localparam int RXC_W     = clog2_w(IN_BEATS);
    localparam int WD_W      = clog2_w((TIMEOUT > 0) ? TIMEOUT : 1);

    bridge_state_e        state_q, state_d;
    logic [OUT_WIDTH-1:0] shadow_q, shadow_d;
    logic [IN_WIDTH-1:0]  asm_q, asm_d;
    logic [IN_WIDTH-1:0]  in_vec_q, in_vec_d;
    logic [TXC_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [RXC_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [WD_W-1:0]      wdog_q, wdog_d;
    logic                 pending_q, pending_d;
    logic                 auto_ok_q, auto_ok_d;   // last frame completed normally
    logic                 terr_q, terr_d;
    logic                 stall;

    logic [LANE_WIDTH-1:0] tx_lane;
    logic [LANE_WIDTH-1:0] unused_rx_lane;
    logic [OUT_WIDTH-1:0]  unused_tx_vec;
    logic [IN_WIDTH-1:0]   asm_ins;

    bridge_lane_mux #(.VEC_W(OUT_WIDTH), .LANE_W(LANE_WIDTH), .IDX_W(TXC_W)) u_tx_sel (
        .vec_i  (shadow_q),
        .idx_i  (tx_cnt_q),
        .lane_i ({LANE_WIDTH{1'b0}}),
        .lane_o (tx_lane),
        .vec_o  (unused_tx_vec)
    );

    bridge_lane_mux #(.VEC_W(IN_WIDTH), .LANE_W(LANE_WIDTH), .IDX_W(RXC_W)) u_rx_ins (
        .vec_i  (asm_q),
        .idx_i  (rx_cnt_q),
        .lane_i (link.rx_data),
        .lane_o (unused_rx_lane),
        .vec_o  (asm_ins)
    );

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        asm_d     = asm_q;
        in_vec_d  = in_vec_q;
        tx_cnt_d  = tx_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        wdog_d    = '0;          // any cycle that is not a stall restarts the watchdog
        pending_d = pending_q;
        auto_ok_d = auto_ok_q;
        terr_d    = terr_q;
        stall     = 1'b0;

        if (frame_req) terr_d = 1'b0;
        if (frame_req && state_q != ST_IDLE) pending_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (frame_req || pending_q || (auto_en && auto_ok_q)) begin
                    state_d   = ST_TX;
                    shadow_d  = out_vec;
                    pending_d = 1'b0;
                    terr_d    = 1'b0;
                    tx_cnt_d  = '0;
                    rx_cnt_d  = '0;
                end
            end
            ST_TX: begin
                if (link.tx_ready) begin
                    if (tx_cnt_q == TXC_W'(OUT_BEATS - 1)) begin
                        tx_cnt_d = '0;
                        state_d  = ST_RX;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 1'b1;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            ST_RX: begin
                if (link.rx_valid) begin
                    asm_d = asm_ins;
                    if (rx_cnt_q == RXC_W'(IN_BEATS - 1)) begin
                        rx_cnt_d = '0;
                        state_d  = ST_COMMIT;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            ST_COMMIT: begin
                in_vec_d  = asm_q;
                auto_ok_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort fires on the TIMEOUT-th consecutive stalled cycle. It drops
        // any queued request and blocks auto restart until a fresh frame_req.
        if (stall && TIMEOUT != 0) begin
            if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                state_d   = ST_IDLE;
                terr_d    = 1'b1;
                pending_d = 1'b0;
                auto_ok_d = 1'b0;
                tx_cnt_d  = '0;
                rx_cnt_d  = '0;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shadow_q  <= '0;
            asm_q     <= '0;
            in_vec_q  <= IN_RESET;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            wdog_q    <= '0;
            pending_q <= 1'b0;
            auto_ok_q <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            asm_q     <= asm_d;
            in_vec_q  <= in_vec_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            wdog_q    <= wdog_d;
            pending_q <= pending_d;
            auto_ok_q <= auto_ok_d;
            terr_q    <= terr_d;
        end
    end

    // All outputs decode registered state only, so they cannot glitch.
    assign busy          = (state_q != ST_IDLE);
    assign frame_done    = (state_q == ST_COMMIT);
    assign timeout_err   = terr_q;
    assign in_vec        = in_vec_q;
    assign link.tx_valid = (state_q == ST_TX);
    assign link.tx_data  = (state_q == ST_TX) ? tx_lane : '0;
    assign link.rx_ready = (state_q == ST_RX);

endmodule

// File: tb/tb_digital_io_bridge.sv
// ---------------------------------------------------------------------------
// tb_digital_io_bridge
//   Scoreboard bench: stimulus pushes the expected outbound beats and the
//   expected committed in_vec into queues; a monitor pops and compares on
//   every tx handshake and every commit. Host drivers run tx_ready / rx_valid
//   in always-ready, toggling or random modes.
// ---------------------------------------------------------------------------
module tb_digital_io_bridge;
    localparam int OW = 147;
    localparam int IW = 43;
    localparam int LW = 8;
    localparam int TO = 16;
    localparam int OBEATS = (OW + LW - 1) / LW;
    localparam int IBEATS = (IW + LW - 1) / LW;

    logic          clk;
    logic          rst;
    logic [OW-1:0] out_vec;
    logic [IW-1:0] in_vec;
    logic          frame_req, auto_en;
    logic          busy, frame_done, timeout_err;

    digital_io_bridge_if #(.LANE_WIDTH(LW)) link ();

    digital_io_bridge #(
        .OUT_WIDTH(OW), .IN_WIDTH(IW), .LANE_WIDTH(LW),
        .IN_RESET({IW{1'b0}}), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .out_vec(out_vec), .in_vec(in_vec),
        .frame_req(frame_req), .auto_en(auto_en), .busy(busy),
        .frame_done(frame_done), .timeout_err(timeout_err), .link(link)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int rx_hs_cnt = 0;
    int tx_mode = 0;   // 0 always ready, 1 toggle, 2 random
    int rx_mode = 0;   // 0 always valid when data queued, 2 random

    logic [LW-1:0] exp_tx_q[$];
    logic [IW-1:0] exp_in_q[$];
    logic [LW-1:0] rx_q[$];
    logic [IW-1:0] last_in = '0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [OW-1:0] rand_vec();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[OW-1:0];
    endfunction

    function automatic logic [47:0] rand48();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[47:0];
    endfunction

    // Outbound: beat k is bits k*8.. of the snapshot, zero above OW.
    task automatic push_tx(input logic [OW-1:0] v);
        logic [OW-1:0] s;
        for (int k = 0; k < OBEATS; k++) begin
            s = v >> (LW * k);
            exp_tx_q.push_back(s[LW-1:0]);
        end
    endtask

    // Inbound: bytes sent LSB first, committed value is their little-endian
    // concatenation truncated to IW bits.
    task automatic push_rx(input logic [47:0] w);
        for (int j = 0; j < IBEATS; j++) rx_q.push_back(w[j*LW +: LW]);
        exp_in_q.push_back(w[IW-1:0]);
    endtask

    // ---------------- host driver ----------------
    initial begin
        logic rx_hs;
        link.tx_ready = 1'b0;
        link.rx_valid = 1'b0;
        link.rx_data  = '0;
        forever begin
            @(negedge clk);
            rx_hs = link.rx_valid && link.rx_ready && rst;
            @(posedge clk);
            #1;
            if (rx_hs && rx_q.size() > 0) begin
                void'(rx_q.pop_front());
                rx_hs_cnt++;
            end
            case (tx_mode)
                0:       link.tx_ready = 1'b1;
                1:       link.tx_ready = !link.tx_ready;
                default: link.tx_ready = ($urandom_range(0, 9) >= 3);
            endcase
            if (rx_q.size() > 0 && (rx_mode == 0 || $urandom_range(0, 9) >= 3)) begin
                link.rx_valid = 1'b1;
                link.rx_data  = rx_q[0];
            end else begin
                link.rx_valid = 1'b0;
                link.rx_data  = LW'($urandom());
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic          held_v = 1'b0;
    logic [LW-1:0] held_d = '0;
    logic [IW-1:0] prev_in = '0;
    logic          commit_pend = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            held_v      = 1'b0;
            commit_pend = 1'b0;
            prev_in     = in_vec;
        end else begin
            if (link.tx_valid) begin
                if (held_v) chk("tx_stable", link.tx_data, held_d);
                if (link.tx_ready) begin
                    if (exp_tx_q.size() == 0) chk("tx_extra_beat", 1, 0);
                    else chk("tx_beat", link.tx_data, exp_tx_q.pop_front());
                    held_v = 1'b0;
                end else begin
                    held_v = 1'b1;
                    held_d = link.tx_data;
                end
            end else begin
                held_v = 1'b0;
                chk("tx_idle_zero", link.tx_data, 0);
            end
            if (commit_pend) begin
                if (exp_in_q.size() == 0) chk("commit_extra", 1, 0);
                else begin
                    last_in = exp_in_q.pop_front();
                    chk("commit_in_vec", in_vec, last_in);
                end
                commit_pend = 1'b0;
            end else if (in_vec !== prev_in) begin
                chk("in_vec_outside_commit", in_vec, prev_in);
            end
            prev_in = in_vec;
            if (frame_done) begin
                commit_pend = 1'b1;
                done_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_req();
        @(posedge clk); #1 frame_req = 1'b1;
        @(posedge clk); #1 frame_req = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("frames_done", done_cnt, target);
    endtask

    initial begin
        int cyc, base, rcnt;
        logic seen;
        logic [OW-1:0] va, vb;
        rst = 1'b0; frame_req = 1'b0; auto_en = 1'b0; out_vec = '0;
        #2;
        chk("in_reset", {in_vec, busy, link.tx_valid, link.rx_ready, frame_done, timeout_err}, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // idle after reset, no requests
        repeat (10) begin
            @(negedge clk);
            chk("reset_idle", {in_vec, link.tx_valid, link.rx_ready, busy, frame_done, timeout_err, link.tx_data}, 0);
        end

        // directed full frame, always-ready host, latency
        tx_mode = 0; rx_mode = 0;
        va = {3'h5, {18{8'hA5}}};
        out_vec = va;
        push_tx(va);
        push_rx(48'h06_05_04_03_02_01);
        @(posedge clk); #1 frame_req = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) frame_req = 1'b0;
        end while (!frame_done && cyc < 100);
        frame_req = 1'b0;
        chk("frame_latency", cyc, 27);
        @(negedge clk);
        chk("directed_in_vec", in_vec, 43'h605_0403_0201);
        repeat (3) @(negedge clk);

        // backpressure: tx_ready toggles every cycle
        tx_mode = 1;
        va = rand_vec();
        out_vec = va;
        push_tx(va);
        push_rx(rand48());
        base = done_cnt;
        pulse_req();
        wait_done(base + 1, 300);
        tx_mode = 0;
        repeat (3) @(negedge clk);

        // snapshot and pending coalescing
        va = rand_vec();
        vb = ~va;
        out_vec = va;
        push_tx(va); push_rx(rand48());
        push_tx(vb); push_rx(rand48());
        base = done_cnt;
        pulse_req();
        repeat (3) @(posedge clk);
        #1 out_vec = vb;
        pulse_req();
        pulse_req();
        wait_done(base + 2, 400);
        repeat (40) @(negedge clk);
        chk("pending_one_extra", done_cnt, base + 2);
        chk("pending_idle", busy, 0);

        // randomized frames with random host stalls and live out_vec churn
        tx_mode = 2; rx_mode = 2;
        for (int f = 0; f < 6; f++) begin
            va = rand_vec();
            out_vec = va;
            push_tx(va);
            push_rx(rand48());
            base = done_cnt;
            pulse_req();
            repeat ($urandom_range(1, 10)) @(posedge clk);
            #1 out_vec = rand_vec();
            wait_done(base + 1, 400);
            repeat ($urandom_range(2, 5)) @(negedge clk);
        end
        tx_mode = 0; rx_mode = 0;
        repeat (3) @(negedge clk);

        // watchdog: no rx beats supplied
        va = rand_vec();
        out_vec = va;
        push_tx(va);
        pulse_req();
        rcnt = 0; cyc = 0;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (link.rx_ready) rcnt++;
            if (!busy) break;
        end
        chk("timeout_rx_cycles", rcnt, TO);
        chk("timeout_err_set", timeout_err, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_in_vec_kept", in_vec, last_in);
        chk("timeout_tx_drained", exp_tx_q.size(), 0);

        // auto_en must not restart after an abort
        @(posedge clk); #1 auto_en = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        chk("auto_suppressed", seen, 0);
        chk("timeout_err_sticky", timeout_err, 1);

        // frame_req clears the error; auto_en chains exactly one more frame
        va = rand_vec();
        out_vec = va;
        push_tx(va); push_rx(rand48());
        push_tx(va); push_rx(rand48());
        base = done_cnt;
        pulse_req();
        @(negedge clk);
        chk("timeout_err_cleared", timeout_err, 0);
        wait_done(base + 1, 300);
        repeat (4) @(negedge clk);
        chk("auto_restart", busy, 1);
        @(posedge clk); #1 auto_en = 1'b0;
        wait_done(base + 2, 300);
        repeat (40) @(negedge clk);
        chk("auto_stop", done_cnt, base + 2);

        // async reset in the middle of RX
        va = rand_vec();
        out_vec = va;
        push_tx(va);
        push_rx(rand48());
        base = rx_hs_cnt;
        pulse_req();
        cyc = 0;
        do begin
            @(posedge clk); #2;
            cyc++;
        end while (rx_hs_cnt < base + 3 && cyc < 200);
        chk("rx_three_beats", rx_hs_cnt, base + 3);
        rst = 1'b0;
        #1;
        chk("mid_rst_in_vec", in_vec, 0);
        chk("mid_rst_outputs", {busy, link.tx_valid, link.rx_ready, frame_done, timeout_err}, 0);
        exp_tx_q.delete();
        exp_in_q.delete();
        rx_q.delete();
        last_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);

        // clean frame after reset
        va = rand_vec();
        out_vec = va;
        push_tx(va);
        push_rx(rand48());
        base = done_cnt;
        pulse_req();
        wait_done(base + 1, 300);
        repeat (3) @(negedge clk);

        chk("tx_queue_empty", exp_tx_q.size(), 0);
        chk("in_queue_empty", exp_in_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "bench time limit");
    end
endmodule

// File: doc/digital_io_bridge.md
Name: digital_io_bridge

Overview:
- Synthesizable framed bridge between the SoC's packed pin vectors and an external co-simulator or host link.
- Snapshots a wide output vector and streams it out LANE_WIDTH bits per beat.
- Then streams in a wide input vector and commits it atomically to the SoC side.
- Replaces ad-hoc per-cycle whole-vector exchange with handshaked, width-independent, glitch-free transfers.

Parameters:
- OUT_WIDTH, 147, width of SoC-to-host vector (out_vec).
- IN_WIDTH, 43, width of host-to-SoC vector (in_vec).
- LANE_WIDTH, 8, bits per link beat.
- IN_RESET, {IN_WIDTH{1'b0}}, value of in_vec after reset (pulldown default).
- TIMEOUT, 1024, max idle cycles waiting on a handshake before abort; 0 disables.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- out_vec  in  OUT_WIDTH  live SoC outputs to export
- in_vec  out  OUT: IN_WIDTH  committed host inputs to SoC
- frame_req  in  1  pulse: start one exchange frame
- auto_en  in  1  when 1, start a new frame immediately after each completes
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse on commit
- timeout_err  out  1  sticky; set on watchdog abort, cleared by next frame_req
- tx_data  out  LANE_WIDTH  outbound beat
- tx_valid  out  1  outbound beat valid
- tx_ready  in  1  host accepts beat
- rx_data  in  LANE_WIDTH  inbound beat
- rx_valid  in  1  inbound beat valid
- rx_ready  out  1  bridge accepts beat

Behaviour:
- Reset (rst=0, async): state IDLE; in_vec=IN_RESET; tx_valid=0, tx_data=0, rx_ready=0, busy=0, frame_done=0, timeout_err=0; beat counters=0; pending=0.
- OUT_BEATS=ceil(OUT_WIDTH/LANE_WIDTH), IN_BEATS=ceil(IN_WIDTH/LANE_WIDTH).
- States: IDLE, TX, RX, COMMIT.
- IDLE to TX on the cycle after (frame_req | pending | (auto_en & previous frame completed)).
  - On the same edge, snapshot out_vec into a shadow register.
  - Set busy=1 and clear timeout_err.
- TX:
  - tx_valid=1; tx_data = shadow bits [k*LANE_WIDTH +: LANE_WIDTH], beat k from 0, LSB chunk first.
  - Bits above OUT_WIDTH in the last beat are 0.
  - A beat transfers when tx_valid & tx_ready. tx_data stays stable until the transfer.
  - After beat OUT_BEATS-1 transfers, go to RX; tx_valid drops the next cycle.
- RX:
  - rx_ready=1.
  - Beat j is written into the assembly register [j*LANE_WIDTH +: LANE_WIDTH] on rx_valid & rx_ready.
  - Excess bits of the last beat are discarded.
  - After beat IN_BEATS-1, go to COMMIT.
- COMMIT (1 cycle):
  - in_vec <= assembly register.
  - frame_done=1; busy drops next cycle; return to IDLE.
  - in_vec changes only here, never partially.
- Minimum frame latency: 1 + OUT_BEATS + IN_BEATS + 1 cycles with handshakes always ready (defaults: 27).
- frame_req while busy: sets pending (one deep; extra requests coalesce). Pending is consumed on return to IDLE.
- out_vec changes during a frame do not affect the frame in flight (shadow).
- Watchdog:
  - Counts consecutive cycles in TX with !tx_ready, or in RX with !rx_valid; reset on every transfer.
  - Reaching TIMEOUT: abort to IDLE, timeout_err=1, in_vec unchanged, pending cleared, auto_en restart suppressed until the next frame_req.
- Async reset mid-frame: immediate return to reset values, including in_vec=IN_RESET; partial beats are lost.
- OUT_WIDTH or IN_WIDTH < LANE_WIDTH is legal (1 beat each). LANE_WIDTH=1 is legal.

Decomposition:
- Shared package digital_bridge_pkg:
  - state encoding (IDLE=2'd0, TX=2'd1, RX=2'd2, COMMIT=2'd3);
  - ceil-div function for beat counts;
  - clog2 helper for counter widths.
- One natural sub-module: bridge_lane_mux. Parametrised chunk select/insert (index to LANE_WIDTH slice, zero-pad / truncate), instanced once for TX select and once for RX insert.
- FSM, counters and watchdog stay in the top.

Test Plan:
- Reset, defaults: rst low then high, no requests -> in_vec=0, tx_valid=0, rx_ready=0, busy=0 indefinitely.
- Full frame, always-ready host: out_vec=147'h5_A5A5... pattern, rx feeds 6 beats 8'h01..8'h06 -> 19 tx beats with chunk 0 = out_vec[7:0], last beat upper 5 bits 0; in_vec=43'h006_0504_0302_01 masked to 43 bits; frame_done on cycle 27 after frame_req.
- Backpressure: tx_ready toggles 0/1 every cycle -> tx_data held stable across stalls; all 19 beats in order; no duplicates.
- Snapshot and pending: change out_vec at beat 3 and pulse frame_req twice during TX -> frame 1 carries old value; exactly one extra frame follows carrying new value.
- Timeout: TIMEOUT=16, rx_valid held 0 in RX -> abort after 16 stalled cycles; timeout_err=1; in_vec keeps prior value; busy=0.
- Reset mid-RX: assert rst after 3 rx beats -> in_vec=IN_RESET immediately; next frame starts clean from beat 0.
